// File: rtl/mips32i_decode_stage.sv
// MIPS32 decode stage: field split, immediate extension, branch/jump targets.
// Two-entry skid buffer keeps in_ready a pure register output.
module mips32i_decode_stage #(
  parameter int PC_WIDTH      = 32,
  parameter int IMM_EXT_WIDTH = 32,
  parameter bit ZEXT_LOGICAL  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instruction,
  input  logic [PC_WIDTH-1:0]      in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [5:0]               out_opcode,
  output logic [4:0]               out_rs,
  output logic [4:0]               out_rt,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_shamt,
  output logic [5:0]               out_funct,
  output logic [IMM_EXT_WIDTH-1:0] out_imm_ext,
  output logic [PC_WIDTH-1:0]      out_br_target,
  output logic [PC_WIDTH-1:0]      out_j_target,
  output logic                     out_is_r,
  output logic                     out_is_i,
  output logic                     out_is_j,
  output logic [PC_WIDTH-1:0]      out_pc
);

  typedef struct packed {
    logic [5:0]               opcode;
    logic [4:0]               rs;
    logic [4:0]               rt;
    logic [4:0]               rd;
    logic [4:0]               shamt;
    logic [5:0]               funct;
    logic [IMM_EXT_WIDTH-1:0] imm_ext;
    logic [PC_WIDTH-1:0]      br_target;
    logic [PC_WIDTH-1:0]      j_target;
    logic                     is_r;
    logic                     is_i;
    logic                     is_j;
    logic [PC_WIDTH-1:0]      pc;
  } dec_t;

  dec_t                dec;
  dec_t                main_q;
  dec_t                skid_q;
  logic                main_v;
  logic                skid_v;
  logic [PC_WIDTH-1:0] pc4;
  logic [15:0]         imm16;
  logic                logical;

  always_comb begin
    dec     = '0;
    pc4     = in_pc + PC_WIDTH'(4);
    imm16   = in_instruction[15:0];
    dec.opcode = in_instruction[31:26];
    dec.rs     = in_instruction[25:21];
    dec.rt     = in_instruction[20:16];
    dec.rd     = in_instruction[15:11];
    dec.shamt  = in_instruction[10:6];
    dec.funct  = in_instruction[5:0];
    dec.pc     = in_pc;
    logical = ZEXT_LOGICAL &&
              (dec.opcode inside {6'h0c, 6'h0d, 6'h0e});
    dec.imm_ext = logical ? IMM_EXT_WIDTH'(imm16)
                          : IMM_EXT_WIDTH'($signed(imm16));
    dec.br_target = pc4 + PC_WIDTH'($signed({imm16, 2'b00}));
    dec.j_target = pc4;
    dec.j_target[27:0] = {in_instruction[25:0], 2'b00};
    unique case (1'b1)
      (dec.opcode == 6'h00): dec.is_r = 1'b1;
      (dec.opcode == 6'h02),
      (dec.opcode == 6'h03): dec.is_j = 1'b1;
      default:               dec.is_i = 1'b1;
    endcase
  end

  // Skid only fills while main is stalled; in_ready is simply !skid_v.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || out_ready) begin
      if (skid_v) begin
        main_q <= skid_q;
        main_v <= 1'b1;
        skid_v <= 1'b0;
      end else if (in_valid) begin
        main_q <= dec;
        main_v <= 1'b1;
      end else begin
        main_v <= 1'b0;
      end
    end else if (in_valid && !skid_v) begin
      skid_q <= dec;
      skid_v <= 1'b1;
    end
  end

  assign in_ready      = !skid_v;
  assign out_valid     = main_v;
  assign out_opcode    = main_q.opcode;
  assign out_rs        = main_q.rs;
  assign out_rt        = main_q.rt;
  assign out_rd        = main_q.rd;
  assign out_shamt     = main_q.shamt;
  assign out_funct     = main_q.funct;
  assign out_imm_ext   = main_q.imm_ext;
  assign out_br_target = main_q.br_target;
  assign out_j_target  = main_q.j_target;
  assign out_is_r      = main_q.is_r;
  assign out_is_i      = main_q.is_i;
  assign out_is_j      = main_q.is_j;
  assign out_pc        = main_q.pc;

endmodule
